// File: rtl/udp_rate_sched.sv
`default_nettype none
// ============================================================================
// Module   : udp_rate_sched
// Brief    : Per-channel phase-accumulator packet pacing with credit banking
//            and round-robin arbitration onto one shared UDP transmitter.
// Revision : 1.0
// ============================================================================
module udp_rate_sched #(
    parameter int N_CH   = 4,
    parameter int PEND_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [32*N_CH-1:0]   speed,
    input  logic                 ovf_clr,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 tx_start,
    output logic [2:0]           tx_ch,
    output logic [N_CH-1:0]      pend_nz,
    output logic [N_CH-1:0]      ovf
);
    localparam logic [PEND_W-1:0] C_CRED_MAX  = '1;
    localparam logic [2:0]        C_LAST_INIT = 3'(N_CH - 1);
    localparam int                C_IW        = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_last;
    logic [2:0]      r_tx_ch;
    logic            r_tx_start;
    logic [N_CH-1:0] r_pend_nz;
    logic [N_CH-1:0] r_ovf;

    logic [N_CH-1:0] w_pend_nxt;
    logic [N_CH-1:0] w_ovf_set;
    logic            w_grant;
    logic            w_gnt_found;
    logic [2:0]      w_gnt_ch;
    logic [3:0]      w_idx;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            logic [31:0]       r_acc;
            logic [PEND_W-1:0] r_cred;
            logic [PEND_W-1:0] w_cred_nxt;
            logic [32:0]       w_sum;
            logic              w_wrap;
            logic              w_dec;
            logic              w_sat;

            assign w_sum  = {1'b0, r_acc} + {1'b0, speed[32*k +: 32]};
            assign w_wrap = en & w_sum[32];
            assign w_dec  = w_grant && (w_gnt_ch == 3'(k));

            // A wrap and a grant on the same edge cancel, so no saturation there.
            always_comb begin
                w_cred_nxt = r_cred;
                w_sat      = 1'b0;
                if (w_wrap && !w_dec) begin
                    if (r_cred == C_CRED_MAX)
                        w_sat = 1'b1;
                    else
                        w_cred_nxt = r_cred + 1'b1;
                end else if (w_dec && !w_wrap) begin
                    w_cred_nxt = r_cred - 1'b1;
                end
            end

            assign w_pend_nxt[k] = |w_cred_nxt;
            assign w_ovf_set[k]  = w_sat;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_acc  <= '0;
                    r_cred <= '0;
                end else begin
                    if (en)
                        r_acc <= w_sum[31:0];
                    r_cred <= w_cred_nxt;
                end
            end
        end
    endgenerate

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_ch    = r_last;
        w_idx       = '0;
        for (int i = 1; i <= N_CH; i++) begin
            w_idx = {1'b0, r_last} + 4'(i);
            if (w_idx >= 4'(N_CH))
                w_idx = w_idx - 4'(N_CH);
            if (!w_gnt_found && r_pend_nz[w_idx[C_IW-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_ch    = w_idx[2:0];
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && en && !tx_busy && w_gnt_found;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (tx_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_last     <= C_LAST_INIT;
            r_tx_ch    <= '0;
            r_tx_start <= 1'b0;
            r_pend_nz  <= '0;
            r_ovf      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= w_grant;
            if (w_grant) begin
                r_tx_ch <= w_gnt_ch;
                r_last  <= w_gnt_ch;
            end
            r_pend_nz  <= w_pend_nxt;
            r_ovf      <= w_ovf_set | (r_ovf & ~{N_CH{ovf_clr}});
        end
    end

    assign tx_start = r_tx_start;
    assign tx_ch    = r_tx_ch;
    assign pend_nz  = r_pend_nz;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire
